// File: rtl/fetch_predictor.sv
// fetch_predictor: direct-mapped BTB with saturating direction counters, EX training and perf counters
module fetch_predictor #(
  parameter int DWIDTH   = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_en,
  input  logic [DWIDTH-1:0] if_pc,
  output logic [DWIDTH-1:0] if_npc,
  output logic              if_pred_taken,
  input  logic              ex_update,
  input  logic [DWIDTH-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [DWIDTH-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [DWIDTH-1:0] ex_pred_target,
  output logic              ex_mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = DWIDTH - IDX - 2;
  localparam logic [CTR_BITS-1:0] THR = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic                valid_q  [ENTRIES];
  logic [TW-1:0]       tag_q    [ENTRIES];
  logic [DWIDTH-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [IDX-1:0] if_idx, ex_idx;
  logic [TW-1:0]  if_tag, ex_tag;
  logic           ex_hit;
  always_comb begin
    if_idx = if_pc[IDX+1:2];
    if_tag = if_pc[DWIDTH-1:IDX+2];
    ex_idx = ex_pc[IDX+1:2];
    ex_tag = ex_pc[DWIDTH-1:IDX+2];
    ex_hit = valid_q[ex_idx] && tag_q[ex_idx] == ex_tag;
    if_pred_taken = pred_en && valid_q[if_idx] && tag_q[if_idx] == if_tag && ctr_q[if_idx] >= THR;
    if_npc = if_pred_taken ? target_q[if_idx] : if_pc + DWIDTH'(4);
    ex_mispredict = ex_update && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= WEAK;
        target_q[i] <= '0;
      end
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (ex_update) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_taken ? (ctr_q[ex_idx] == CTR_MAX ? CTR_MAX : ctr_q[ex_idx] + 1'b1)
                                  : (ctr_q[ex_idx] == '0 ? '0 : ctr_q[ex_idx] - 1'b1);
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= THR;
      end
      branch_cnt <= branch_cnt == CNT_MAX ? CNT_MAX : branch_cnt + 1'b1;
      if (ex_mispredict) miss_cnt <= miss_cnt == CNT_MAX ? CNT_MAX : miss_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_predictor.sv
// tb_fetch_predictor: directed vectors with a queued scoreboard checked at each falling edge
module tb_fetch_predictor;
  logic        clk = 1'b0;
  logic        rst, pred_en, ex_update, ex_taken, ex_pred_taken;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target, if_npc;
  logic        if_pred_taken, ex_mispredict;
  logic [3:0]  branch_cnt, miss_cnt;
  int          checks = 0;
  int          fails = 0;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  fetch_predictor #(.DWIDTH(32), .ENTRIES(16), .CTR_BITS(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pred_en(pred_en), .if_pc(if_pc), .if_npc(if_npc),
    .if_pred_taken(if_pred_taken), .ex_update(ex_update), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_mispredict(ex_mispredict),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = e.sel == 0 ? if_npc : e.sel == 1 ? 32'(if_pred_taken) : e.sel == 2 ? 32'(ex_mispredict)
          : e.sel == 3 ? 32'(branch_cnt) : 32'(miss_cnt);
      checks++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end
  task automatic expect_v(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endtask
  task automatic pred(input string name, input logic [31:0] npc, input logic tk);
    expect_v({name, "_npc"}, 0, npc);
    expect_v({name, "_taken"}, 1, 32'(tk));
  endtask
  task automatic cnts(input string name, input logic [3:0] b, input logic [3:0] m);
    expect_v({name, "_branch_cnt"}, 3, 32'(b));
    expect_v({name, "_miss_cnt"}, 4, 32'(m));
  endtask
  task automatic ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt);
    ex_update = 1'b1;
    ex_pc = pc;
    ex_taken = tk;
    ex_target = tgt;
    ex_pred_taken = ptk;
    ex_pred_target = ptgt;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
    ex_update = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    pred_en = 1'b1;
    if_pc = 32'h40;
    ex_update = 1'b0;
    ex_pc = '0;
    ex_taken = 1'b0;
    ex_target = '0;
    ex_pred_taken = 1'b0;
    ex_pred_target = '0;
    cyc();
    rst = 1'b0;
    checks++;
    if (if_npc !== 32'h44 || if_pred_taken !== 1'b0 || branch_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: npc 0x%0h taken %0b cnt %0d/%0d", if_npc, if_pred_taken, branch_cnt, miss_cnt);
    end
    pred("reset", 32'h44, 1'b0);
    cnts("reset", 0, 0);
    expect_v("reset_mispredict", 2, 0);
    cyc();
    ex(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    expect_v("alloc_mispredict", 2, 1);
    pred("alloc_same_cycle", 32'h44, 1'b0);
    cyc();
    pred("alloc_predict", 32'h100, 1'b1);
    cnts("alloc", 1, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      ex(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      expect_v("train_taken_mispredict", 2, 0);
      cyc();
    end
    cnts("train_taken", 4, 1);
    ex(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    expect_v("nt1_mispredict", 2, 1);
    cyc();
    pred("hysteresis_nt1", 32'h100, 1'b1);
    ex(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    cyc();
    pred("hysteresis_nt2", 32'h44, 1'b0);
    cnts("hysteresis", 6, 3);
    ex(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    expect_v("alias_mispredict", 2, 1);
    cyc();
    pred("alias_old", 32'h44, 1'b0);
    cyc();
    if_pc = 32'h80;
    pred("alias_new", 32'h200, 1'b1);
    ex(32'h80, 1'b1, 32'h300, 1'b1, 32'h100);
    expect_v("target_change_mispredict", 2, 1);
    cyc();
    pred("target_change", 32'h300, 1'b1);
    cnts("target_change", 8, 5);
    cyc();
    pred_en = 1'b0;
    pred("pred_disabled", 32'h84, 1'b0);
    cyc();
    pred_en = 1'b1;
    ex(32'hC0, 1'b0, 32'h999, 1'b0, 32'hC4);
    expect_v("miss_nt_mispredict", 2, 0);
    cyc();
    if_pc = 32'hC0;
    pred("miss_nt_no_alloc", 32'hC4, 1'b0);
    cnts("miss_nt", 9, 5);
    cyc();
    if_pc = 32'hFFFF_FFFC;
    pred("pc_wrap", 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ex(32'h1000, 1'b0, 32'h0, 1'b1, 32'h500);
      cyc();
      if (i == 5) cnts("sat_mid", 15, 11);
    end
    cnts("sat_end", 15, 15);
    cyc();
    rst = 1'b1;
    ex(32'h80, 1'b1, 32'h500, 1'b0, 32'h84);
    cyc();
    rst = 1'b0;
    if_pc = 32'h80;
    pred("reset_priority", 32'h84, 1'b0);
    cnts("reset_priority", 0, 0);
    cyc();
    if_pc = 32'h40;
    pred("reset_clears_40", 32'h44, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL expired_wait: %0d expectations never evaluated", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
